// File: rtl/vedic_mul_pkg.sv
// Shared definitions for the sequential Vedic multiplier: FSM encodings, step count
// and the per-step partial-product shift table.
package vedic_mul_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam int N_STEPS = 4;

  // Step order: aL*bL (0), aH*bL (H), aL*bH (H), aH*bH (2H)
  function automatic int step_shift(input logic [1:0] step, input int h);
    case (step)
      2'd0:       return 0;
      2'd1, 2'd2: return h;
      default:    return 2 * h;
    endcase
  endfunction

endpackage

// File: rtl/vedic_mul_seq_ctrl_if.sv
// Operand/result valid-ready bundle for vedic_mul_seq_ctrl.
interface vedic_mul_seq_ctrl_if #(
  parameter int WIDTH = 32
);
  logic                 in_valid;
  logic                 in_ready;
  logic [WIDTH-1:0]     a;
  logic [WIDTH-1:0]     b;
  logic                 out_valid;
  logic                 out_ready;
  logic [2*WIDTH-1:0]   product;
  logic                 busy;

  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, product, busy
  );

  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, product, busy
  );
endinterface

// File: rtl/vedic_half_mul.sv
// Combinational H x H Urdhva-Tiryakbhyam (vertical-and-crosswise) multiplier core:
// each product column sums its crosswise bit pairs plus the carry from the column below.
module vedic_half_mul #(
  parameter int H = 16
) (
  input  logic [H-1:0]   x,
  input  logic [H-1:0]   y,
  output logic [2*H-1:0] p
);

  function automatic logic [2*H-1:0] urdhva(input logic [H-1:0] xv, input logic [H-1:0] yv);
    logic [2*H-1:0] res;
    logic [31:0]    col;
    logic [31:0]    carry;
    int             j;
    res   = '0;
    carry = '0;
    for (int k = 0; k < 2*H-1; k++) begin
      col = carry;
      for (int i = 0; i < H; i++) begin
        j = k - i;
        if (j >= 0 && j < H) col = col + {31'd0, xv[i] & yv[j]};
      end
      res[k] = col[0];
      carry  = col >> 1;
    end
    res[2*H-1] = carry[0];
    return res;
  endfunction

  assign p = urdhva(x, y);

endmodule

// File: rtl/vedic_mul_seq_ctrl.sv
// Iterative WIDTH x WIDTH multiplier: one H x H Vedic core reused over four steps.
// Optional two's-complement operands under macro VEDIC_MUL_SIGNED_EN.
module vedic_mul_seq_ctrl
  import vedic_mul_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  vedic_mul_seq_ctrl_if.slave  bus
);

  localparam int H  = WIDTH / 2;
  localparam int PW = 2 * WIDTH;

  state_t           r_state, w_state_nxt;
  logic [1:0]       r_step;
  logic [WIDTH-1:0] r_a, r_b;
  logic [PW-1:0]    r_acc, r_product;
  logic [PW-1:0]    w_pp_ext, w_term, w_acc_nxt, w_result;
  logic [H-1:0]     w_x, w_y;
  logic [2*H-1:0]   w_pp;
  logic             w_accept, w_last;

`ifdef VEDIC_MUL_SIGNED_EN
  logic r_neg;

  function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v);
    return v[WIDTH-1] ? (~v + 1'b1) : v;
  endfunction
`endif

  assign w_accept = bus.in_valid && (r_state == S_IDLE);
  assign w_last   = (r_state == S_MUL) && (r_step == 2'(N_STEPS - 1));

  // step[0] picks the a half, step[1] picks the b half
  assign w_x = r_step[0] ? r_a[WIDTH-1:H] : r_a[H-1:0];
  assign w_y = r_step[1] ? r_b[WIDTH-1:H] : r_b[H-1:0];

  vedic_half_mul #(.H(H)) u_core (
    .x (w_x),
    .y (w_y),
    .p (w_pp)
  );

  assign w_pp_ext  = PW'(w_pp);
  assign w_term    = w_pp_ext << step_shift(r_step, H);
  assign w_acc_nxt = r_acc + w_term;

`ifdef VEDIC_MUL_SIGNED_EN
  assign w_result = r_neg ? (~w_acc_nxt + 1'b1) : w_acc_nxt;
`else
  assign w_result = w_acc_nxt;
`endif

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_accept)      w_state_nxt = S_MUL;
      S_MUL:   if (w_last)        w_state_nxt = S_DONE;
      S_DONE:  if (bus.out_ready) w_state_nxt = S_IDLE;
      default:                    w_state_nxt = S_IDLE;
    endcase
  end

  // Operand latch: loaded only at accept, so later bus activity cannot disturb it
  always_ff @(posedge clk) begin
    if (w_accept) begin
`ifdef VEDIC_MUL_SIGNED_EN
      r_a   <= mag(bus.a);
      r_b   <= mag(bus.b);
      r_neg <= bus.a[WIDTH-1] ^ bus.b[WIDTH-1];
`else
      r_a <= bus.a;
      r_b <= bus.b;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_step    <= '0;
      r_acc     <= '0;
      r_product <= '0;
    end else if (w_accept) begin
      r_step <= '0;
      r_acc  <= '0;
    end else if (r_state == S_MUL) begin
      r_acc  <= w_acc_nxt;
      r_step <= r_step + 2'd1;
      if (w_last) r_product <= w_result;
    end
  end

  assign bus.in_ready  = (r_state == S_IDLE);
  assign bus.busy      = (r_state != S_IDLE);
  assign bus.out_valid = (r_state == S_DONE);
  assign bus.product   = r_product;

endmodule

// File: tb/tb_vedic_mul_seq_ctrl.sv
// Directed bench for vedic_mul_seq_ctrl; expected products are hand-computed and
// selected by VEDIC_MUL_SIGNED_EN where signedness changes the answer.
module tb_vedic_mul_seq_ctrl;

  logic clk;
  logic rst;
  int   n_vec;
  int   n_err;

  vedic_mul_seq_ctrl_if #(.WIDTH(32)) bus_if ();

  vedic_mul_seq_ctrl #(.WIDTH(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Accept a/b, check the 4-cycle latency and product, then drain with out_ready.
  task automatic run(input string tag, input logic [31:0] av, input logic [31:0] bv,
                     input logic [63:0] exp);
    bus_if.a        = av;
    bus_if.b        = bv;
    bus_if.in_valid = 1'b1;
    tick();
    bus_if.in_valid = 1'b0;
    chk({tag, "_busy"}, 64'(bus_if.busy), 64'd1);
    repeat (3) tick();
    chk({tag, "_early_vld"}, 64'(bus_if.out_valid), 64'd0);
    tick();
    chk({tag, "_vld_lat4"}, 64'(bus_if.out_valid), 64'd1);
    chk({tag, "_product"}, bus_if.product, exp);
    bus_if.out_ready = 1'b1;
    tick();
    bus_if.out_ready = 1'b0;
    chk({tag, "_rdy_after"}, 64'(bus_if.in_ready), 64'd1);
  endtask

  initial begin
    logic [63:0] exp_ff;
    logic [63:0] exp_sgn;
    logic        saw_vld;
    n_vec = 0;
    n_err = 0;
    rst   = 1'b1;
    bus_if.in_valid  = 1'b0;
    bus_if.out_ready = 1'b0;
    bus_if.a         = '0;
    bus_if.b         = '0;

    repeat (2) tick();
    rst = 1'b0;
    chk("rst_in_ready", 64'(bus_if.in_ready), 64'd1);
    chk("rst_out_valid", 64'(bus_if.out_valid), 64'd0);
    chk("rst_busy", 64'(bus_if.busy), 64'd0);
    chk("rst_product", bus_if.product, 64'd0);

`ifdef VEDIC_MUL_SIGNED_EN
    exp_ff  = 64'h0000000000000001;
    exp_sgn = 64'hFFFFFFFFFFFFFFEB;
`else
    exp_ff  = 64'hFFFFFFFE00000001;
    exp_sgn = 64'h00000006FFFFFFEB;
`endif
    run("all_ones", 32'hFFFFFFFF, 32'hFFFFFFFF, exp_ff);
    run("aL_bH", 32'h0000FFFF, 32'h00010000, 64'h00000000FFFF0000);
    run("aH_bH", 32'h00010000, 32'h00010000, 64'h0000000100000000);
    run("aH_bL", 32'h00010000, 32'h0000FFFF, 64'h00000000FFFF0000);
    run("mixed", 32'h00020003, 32'h00050007, 64'h0000000A001D0015);

    // Backpressure: 6*9 held in DONE while a new operand pair is offered
    bus_if.a        = 32'd6;
    bus_if.b        = 32'd9;
    bus_if.in_valid = 1'b1;
    tick();
    bus_if.in_valid = 1'b0;
    repeat (4) tick();
    for (int i = 0; i < 10; i++) begin
      if (i == 2) begin
        bus_if.a        = 32'd100;
        bus_if.b        = 32'd100;
        bus_if.in_valid = 1'b1;
      end else begin
        bus_if.in_valid = 1'b0;
      end
      chk("bp_vld", 64'(bus_if.out_valid), 64'd1);
      chk("bp_prod", bus_if.product, 64'd54);
      chk("bp_rdy", 64'(bus_if.in_ready), 64'd0);
      tick();
    end
    bus_if.in_valid  = 1'b0;
    bus_if.out_ready = 1'b1;
    tick();
    bus_if.out_ready = 1'b0;
    chk("bp_rdy_after", 64'(bus_if.in_ready), 64'd1);
    chk("bp_vld_after", 64'(bus_if.out_valid), 64'd0);
    chk("bp_prod_kept", bus_if.product, 64'd54);
    chk("bp_ignored_busy", 64'(bus_if.busy), 64'd0);

    // Abort: reset while step 2 of 5*7 is in progress
    bus_if.a        = 32'd5;
    bus_if.b        = 32'd7;
    bus_if.in_valid = 1'b1;
    tick();
    bus_if.in_valid = 1'b0;
    repeat (2) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort_rdy", 64'(bus_if.in_ready), 64'd1);
    chk("abort_vld", 64'(bus_if.out_valid), 64'd0);
    chk("abort_busy", 64'(bus_if.busy), 64'd0);
    chk("abort_prod", bus_if.product, 64'd0);
    saw_vld = 1'b0;
    repeat (6) begin
      tick();
      saw_vld = saw_vld | bus_if.out_valid;
    end
    chk("abort_no_vld", 64'(saw_vld), 64'd0);
    run("post_abort", 32'd3, 32'd4, 64'd12);

    run("signedness", 32'hFFFFFFFD, 32'd7, exp_sgn);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
